tl_ul_client_arbiter: RTL



---
 rtl/tl_ul_client_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tl_ul_client_arbiter.sv
// Two-client TL-UL arbiter sharing one manager port. The A channel passes through combinationally with round-robin grant and a source-ID extended by the client bit.
// D responses are routed back by that bit. Backpressure passes straight through on both channels, and an outstanding limit gates each client.
module tl_ul_client_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                c0_a_valid,
  output logic                c0_a_ready,
  input  logic [2:0]          c0_a_opcode,
  input  logic [2:0]          c0_a_size,
  input  logic [SRC_W-1:0]    c0_a_source,
  input  logic [ADDR_W-1:0]   c0_a_address,
  input  logic [DATA_W/8-1:0] c0_a_mask,
  input  logic [DATA_W-1:0]   c0_a_data,
  output logic                c0_d_valid,
  input  logic                c0_d_ready,
  output logic [2:0]          c0_d_opcode,
  output logic [2:0]          c0_d_size,
  output logic [SRC_W-1:0]    c0_d_source,
  output logic                c0_d_denied,
  output logic [DATA_W-1:0]   c0_d_data,
  input  logic                c1_a_valid,
  output logic                c1_a_ready,
  input  logic [2:0]          c1_a_opcode,
  input  logic [2:0]          c1_a_size,
  input  logic [SRC_W-1:0]    c1_a_source,
  input  logic [ADDR_W-1:0]   c1_a_address,
  input  logic [DATA_W/8-1:0] c1_a_mask,
  input  logic [DATA_W-1:0]   c1_a_data,
  output logic                c1_d_valid,
  input  logic                c1_d_ready,
  output logic [2:0]          c1_d_opcode,
  output logic [2:0]          c1_d_size,
  output logic [SRC_W-1:0]    c1_d_source,
  output logic                c1_d_denied,
  output logic [DATA_W-1:0]   c1_d_data,
  output logic                m_a_valid,
  input  logic                m_a_ready,
  output logic [2:0]          m_a_opcode,
  output logic [2:0]          m_a_size,
  output logic [SRC_W:0]      m_a_source,
  output logic [ADDR_W-1:0]   m_a_address,
  output logic [DATA_W/8-1:0] m_a_mask,
  output logic [DATA_W-1:0]   m_a_data,
  input  logic                m_d_valid,
  output logic                m_d_ready,
  input  logic [2:0]          m_d_opcode,
  input  logic [2:0]          m_d_size,
  input  logic [SRC_W:0]      m_d_source,
  input  logic                m_d_denied,
  input  logic [DATA_W-1:0]   m_d_data,
  output logic [3:0]          c0_outstanding,
  output logic [3:0]          c1_outstanding,
  output logic                protocol_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [3:0] cnt0, cnt1;
  logic       prio, lock, lock_idx;
  logic       elig0, elig1, grant, grant_vld, a_fire;
  logic       d_idx, d_fire, inc0, inc1, dec0, dec1;

  assign elig0 = c0_a_valid && (cnt0 < MAX_CNT);
  assign elig1 = c1_a_valid && (cnt1 < MAX_CNT);

  // A stalled request keeps its grant so valid never drops mid-handshake.
  always_comb begin
    grant = 1'b0;
    if (lock)
      grant = lock_idx;
    else if (elig0 && elig1)
      grant = prio;
    else if (elig1)
      grant = 1'b1;
  end

  assign grant_vld  = reset_n && (grant ? elig1 : elig0);
  assign a_fire     = grant_vld && m_a_ready;
  assign m_a_valid  = grant_vld;
  assign c0_a_ready = grant_vld && !grant && m_a_ready;
  assign c1_a_ready = grant_vld && grant && m_a_ready;

  assign m_a_opcode  = grant ? c1_a_opcode  : c0_a_opcode;
  assign m_a_size    = grant ? c1_a_size    : c0_a_size;
  assign m_a_source  = {grant, (grant ? c1_a_source : c0_a_source)};
  assign m_a_address = grant ? c1_a_address : c0_a_address;
  assign m_a_mask    = grant ? c1_a_mask    : c0_a_mask;
  assign m_a_data    = grant ? c1_a_data    : c0_a_data;

  assign d_idx      = m_d_source[SRC_W];
  assign c0_d_valid = reset_n && m_d_valid && !d_idx;
  assign c1_d_valid = reset_n && m_d_valid && d_idx;
  assign m_d_ready  = reset_n && (d_idx ? c1_d_ready : c0_d_ready);
  assign d_fire     = m_d_valid && m_d_ready;

  assign c0_d_opcode = m_d_opcode;
  assign c0_d_size   = m_d_size;
  assign c0_d_source = m_d_source[SRC_W-1:0];
  assign c0_d_denied = m_d_denied;
  assign c0_d_data   = m_d_data;
  assign c1_d_opcode = m_d_opcode;
  assign c1_d_size   = m_d_size;
  assign c1_d_source = m_d_source[SRC_W-1:0];
  assign c1_d_denied = m_d_denied;
  assign c1_d_data   = m_d_data;

  assign inc0 = a_fire && !grant;
  assign inc1 = a_fire && grant;
  assign dec0 = d_fire && !d_idx;
  assign dec1 = d_fire && d_idx;

  // A response against an empty count is an error and must not underflow.
  function automatic logic [3:0] next_cnt(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] sum;
    sum = cnt + {3'b000, inc};
    if (dec && (cnt != 4'd0))
      sum = sum - 4'd1;
    return sum;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0         <= 4'd0;
      cnt1         <= 4'd0;
      prio         <= 1'b0;
      lock         <= 1'b0;
      lock_idx     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      cnt0     <= next_cnt(cnt0, inc0, dec0);
      cnt1     <= next_cnt(cnt1, inc1, dec1);
      lock     <= grant_vld && !m_a_ready;
      lock_idx <= grant;
      if (a_fire)
        prio <= ~grant;
      if ((dec0 && cnt0 == 4'd0) || (dec1 && cnt1 == 4'd0))
        protocol_err <= 1'b1;
    end
  end

  assign c0_outstanding = cnt0;
  assign c1_outstanding = cnt1;

endmodule
